// File: rtl/popcnt_accum_11.sv
// popcnt_accum_11: popcounts an 11-bit beat through an 11-to-4 compressor
// and accumulates the counts over a multi-beat vector closed by in_last.
// One saturating total per vector leaves on a valid/ready output.

// 11-to-4 compressor: full-adder tree reducing eleven 1-bit inputs to a 4-bit count.
module adder_11to4 (
  input  logic [10:0] bits,
  output logic [3:0]  cnt
);

  // Full adder returning {carry, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  logic [1:0] f0, f1, f2;
  logic [1:0] g0, g1;
  logic [1:0] h0, h1;

  // Weight-1 layer: three full adders over bits 0..8.
  assign f0 = fa(bits[0], bits[1], bits[2]);
  assign f1 = fa(bits[3], bits[4], bits[5]);
  assign f2 = fa(bits[6], bits[7], bits[8]);

  // Remaining weight-1 terms fold down to the final LSB.
  assign g0 = fa(f0[0], f1[0], f2[0]);
  assign g1 = fa(g0[0], bits[9], bits[10]);

  // Weight-2 terms fold down to bit 1; the two weight-4 carries form bits 3:2.
  assign h0 = fa(f0[1], f1[1], f2[1]);
  assign h1 = fa(h0[0], g0[1], g1[1]);

  assign cnt = {h0[1] & h1[1], h0[1] ^ h1[1], h1[0], g1[0]};

endmodule

module popcnt_accum_11 #(
  parameter int ACC_W  = 16,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       in_bits,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_sat
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [ACC_W:0]  ACC_MAX  = {1'b0, {ACC_W{1'b1}}};
  localparam logic [BEAT_W:0] BEAT_MAX = {1'b0, {BEAT_W{1'b1}}};

  // Saturating accumulate: returns {saturated, value}; reaching the max counts as saturation.
  function automatic logic [ACC_W:0] sat_acc(input logic [ACC_W-1:0] acc_in,
                                             input logic [3:0] cnt_in);
    logic [ACC_W:0] s;
    s = {1'b0, acc_in} + {{(ACC_W-3){1'b0}}, cnt_in};
    if (s >= ACC_MAX) return {1'b1, ACC_MAX[ACC_W-1:0]};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  // Saturating beat increment: returns {saturated, value}.
  function automatic logic [BEAT_W:0] sat_beats(input logic [BEAT_W-1:0] beats_in);
    logic [BEAT_W:0] s;
    s = {1'b0, beats_in} + {{BEAT_W{1'b0}}, 1'b1};
    if (s >= BEAT_MAX) return {1'b1, BEAT_MAX[BEAT_W-1:0]};
    return {1'b0, s[BEAT_W-1:0]};
  endfunction

  logic [3:0]        beat_cnt;
  logic              s1_valid;
  logic              s1_last;
  logic [3:0]        s1_cnt;
  logic              s1_adv;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt, acc_base;
  logic [BEAT_W-1:0] beats, beats_nxt, beats_base;
  logic              sticky, sticky_nxt;
  logic              load;

  logic              acc_sat, beat_sat;
  logic [ACC_W-1:0]  acc_sum;
  logic [BEAT_W-1:0] beat_sum;

  adder_11to4 u_adder (
    .bits (in_bits),
    .cnt  (beat_cnt)
  );

  // A last beat may only leave S1 when the output register is free or draining.
  assign s1_adv   = s1_valid && (!s1_last || !out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;

  // ---- S0 -> S1: capture the compressor count of each accepted beat ----
  // S1 register: holds one counted beat until it advances into the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_cnt   <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_last  <= in_last;
      s1_cnt   <= beat_cnt;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // ---- S1 -> S2: accumulate, or close the vector on its last beat ----
  // IDLE means a fresh vector, so the running totals start from zero.
  assign acc_base   = (state == IDLE) ? '0 : acc;
  assign beats_base = (state == IDLE) ? '0 : beats;
  assign {acc_sat, acc_sum}   = sat_acc(acc_base, s1_cnt);
  assign {beat_sat, beat_sum} = sat_beats(beats_base);

  // Next-state logic for the accumulator FSM.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    beats_nxt  = beats;
    sticky_nxt = sticky;
    load       = 1'b0;
    if (s1_adv) begin
      if (s1_last) begin
        state_nxt  = IDLE;
        acc_nxt    = '0;
        beats_nxt  = '0;
        sticky_nxt = 1'b0;
        load       = 1'b1;
      end else begin
        state_nxt  = ACCUM;
        acc_nxt    = acc_sum;
        beats_nxt  = beat_sum;
        sticky_nxt = sticky | acc_sat | beat_sat;
      end
    end
  end

  // Accumulator FSM state and running totals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      beats  <= '0;
      sticky <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      beats  <= beats_nxt;
      sticky <= sticky_nxt;
    end
  end

  // ---- S2 -> output: registered result, held while the consumer stalls ----
  // Output register: a new load overrides a same-cycle drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_sum   <= acc_sum;
      out_beats <= beat_sum;
      out_sat   <= sticky | acc_sat | beat_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
